// File: rtl/vga_banner_ctrl.sv
// vga_banner_ctrl: positions and colours a banner for a VGA pixel generator.
// Modes: STATIC (centred), SCROLL (left-to-right wrap), BOUNCE (ping-pong),
// BLINK (centred, colour toggles). Mode changes are requested at any time and
// applied at the next frame boundary; all visible outputs update only on the
// cycle after frame_tick, i.e. during vertical blank.
//
// Optional feature macro: COLOR_CYCLE_EN -- when defined, STATIC/SCROLL/BOUNCE
// advance fg_color every 4 steps through FFFF->F800->07E0->001F->FFFF.
//
// Ports:
//   vga_clk     pixel clock, all state on rising edge
//   sys_rst_n   asynchronous active-low reset
//   pix_x/pix_y current raster position from the timing generator
//   mode_req    one-cycle mode change request, mode_sel sampled with it
//   mode_ack    one-cycle acknowledge, the cycle after mode_req
//   start_x/y   banner top-left corner
//   fg_color    RGB565 glyph colour
//   frame_tick  one-cycle pulse at start of vertical blank
module vga_banner_ctrl #(
    parameter logic [9:0]  H_VALID   = 10'd640,
    parameter logic [9:0]  V_VALID   = 10'd480,
    parameter logic [9:0]  BANNER_W  = 10'd256,
    parameter logic [9:0]  BANNER_H  = 10'd64,
    parameter int unsigned FRAME_DIV = 4,
    parameter logic [9:0]  STEP      = 10'd2
) (
    input  logic        vga_clk,
    input  logic        sys_rst_n,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        mode_req,
    input  logic [1:0]  mode_sel,
    output logic        mode_ack,
    output logic [9:0]  start_x,
    output logic [9:0]  start_y,
    output logic [15:0] fg_color,
    output logic        frame_tick
);

    localparam logic [9:0]  XMAX     = H_VALID - BANNER_W;
    localparam logic [9:0]  CX       = XMAX >> 1;
    localparam logic [9:0]  CY       = (V_VALID - BANNER_H) >> 1;
    localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);
    localparam logic [15:0] WHITE    = 16'hFFFF;
    localparam logic [15:0] BLACK    = 16'h0000;

    typedef enum logic [1:0] {
        ST_STATIC = 2'd0,
        ST_SCROLL = 2'd1,
        ST_BOUNCE = 2'd2,
        ST_BLINK  = 2'd3
    } mode_t;

    mode_t       state, state_n;
    logic [9:0]  start_x_n, start_y_n;
    logic [15:0] fg_color_n;
    logic [3:0]  div_cnt, div_cnt_n;
    logic        dir_right, dir_right_n;
    logic        pend_valid, pend_valid_n;
    logic [1:0]  pend_mode, pend_mode_n;
    logic        step_now;
    logic [10:0] sum11;

`ifdef COLOR_CYCLE_EN
    logic [1:0]  color_cnt, color_cnt_n;

    // Colour sequence used when colour cycling is enabled.
    function automatic logic [15:0] next_color(input logic [15:0] c);
        case (c)
            16'hFFFF: next_color = 16'hF800;
            16'hF800: next_color = 16'h07E0;
            16'h07E0: next_color = 16'h001F;
            default:  next_color = 16'hFFFF;
        endcase
    endfunction
`endif

    // Frame boundary strobe and request acknowledge.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_tick <= 1'b0;
            mode_ack   <= 1'b0;
        end else begin
            frame_tick <= (pix_x == 10'd0) && (pix_y == V_VALID);
            mode_ack   <= mode_req;
        end
    end

    // State register.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= ST_STATIC;
            start_x    <= CX;
            start_y    <= CY;
            fg_color   <= WHITE;
            div_cnt    <= 4'd0;
            dir_right  <= 1'b1;
            pend_valid <= 1'b0;
            pend_mode  <= 2'd0;
`ifdef COLOR_CYCLE_EN
            color_cnt  <= 2'd0;
`endif
        end else begin
            state      <= state_n;
            start_x    <= start_x_n;
            start_y    <= start_y_n;
            fg_color   <= fg_color_n;
            div_cnt    <= div_cnt_n;
            dir_right  <= dir_right_n;
            pend_valid <= pend_valid_n;
            pend_mode  <= pend_mode_n;
`ifdef COLOR_CYCLE_EN
            color_cnt  <= color_cnt_n;
`endif
        end
    end

    assign step_now = (div_cnt == DIV_LAST);
    assign sum11    = 11'(start_x) + 11'(STEP);

    // Next-state: pending request capture, mode apply, per-mode motion step.
    always_comb begin
        state_n      = state;
        start_x_n    = start_x;
        start_y_n    = start_y;
        fg_color_n   = fg_color;
        div_cnt_n    = div_cnt;
        dir_right_n  = dir_right;
        pend_valid_n = pend_valid;
        pend_mode_n  = pend_mode;
`ifdef COLOR_CYCLE_EN
        color_cnt_n  = color_cnt;
`endif

        if (frame_tick) begin
            if (pend_valid) begin
                // Apply the pending mode from a clean initial state; no step.
                state_n      = mode_t'(pend_mode);
                start_x_n    = CX;
                start_y_n    = CY;
                fg_color_n   = WHITE;
                div_cnt_n    = 4'd0;
                dir_right_n  = 1'b1;
                pend_valid_n = 1'b0;
`ifdef COLOR_CYCLE_EN
                color_cnt_n  = 2'd0;
`endif
            end else begin
                div_cnt_n = step_now ? 4'd0 : 4'(div_cnt + 4'd1);
                if (step_now) begin
                    case (state)
                        ST_STATIC: begin
                            start_x_n = CX;
                            start_y_n = CY;
                        end
                        ST_SCROLL: begin
                            start_x_n = (sum11 > 11'(XMAX)) ? 10'd0 : sum11[9:0];
                        end
                        ST_BOUNCE: begin
                            if (dir_right) begin
                                if (sum11 >= 11'(XMAX)) begin
                                    start_x_n   = XMAX;
                                    dir_right_n = 1'b0;
                                end else begin
                                    start_x_n = sum11[9:0];
                                end
                            end else begin
                                // Clamp at 0 rather than underflow.
                                if (11'(start_x) <= 11'(STEP)) begin
                                    start_x_n   = 10'd0;
                                    dir_right_n = 1'b1;
                                end else begin
                                    start_x_n = start_x - STEP;
                                end
                            end
                        end
                        default: begin
                            start_x_n  = CX;
                            start_y_n  = CY;
                            fg_color_n = (fg_color == WHITE) ? BLACK : WHITE;
                        end
                    endcase
`ifdef COLOR_CYCLE_EN
                    if (state != ST_BLINK) begin
                        color_cnt_n = 2'(color_cnt + 2'd1);
                        if (color_cnt == 2'd3) begin
                            fg_color_n = next_color(fg_color);
                        end
                    end
`endif
                end
            end
        end

        // A new request always wins over the clear above (last request wins).
        if (mode_req) begin
            pend_valid_n = 1'b1;
            pend_mode_n  = mode_sel;
        end
    end

endmodule
